// File: rtl/board_state_manager.sv
// board_state_manager: owns the 8x8 board of 4-bit piece codes and the
// side-to-move bit. Accepts one move at a time (valid/ready), checks
// ownership/occupancy, commits it, and streams the board on request.
// Optional feature macro: BOARD_PROMOTION_EN (pawn reaching the far rank
// is written as a queen of the same colour).
module board_state_manager #(
    parameter logic START_PLAYER = 1'b0,
    parameter int   SCAN_GAP     = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       new_game,
    input  logic       move_valid,
    output logic       move_ready,
    input  logic [5:0] move_from,
    input  logic [5:0] move_to,
    output logic       move_done,
    output logic       move_error,
    output logic [3:0] captured,
    output logic       player,
    input  logic       scan_start,
    output logic       scan_valid,
    output logic [5:0] scan_index,
    output logic [3:0] scan_piece,
    output logic       scan_last,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        APPLY     = 2'd1,
        SCAN      = 2'd2,
        SCAN_WAIT = 2'd3
    } state_t;

    // Reload value for the SCAN_WAIT counter; unused when SCAN_GAP is 0.
    localparam logic [1:0] GAP_LOAD = (SCAN_GAP > 0) ? 2'(SCAN_GAP - 1) : 2'd0;

    // Start-position code for a square index (rank*8 + file).
    function automatic logic [3:0] start_code(input int idx);
        int         rank;
        int         file;
        logic [2:0] kind;
        rank = idx / 8;
        file = idx % 8;
        case (file)
            0, 7:    kind = 3'd2;  // rook
            1, 6:    kind = 3'd3;  // knight
            2, 5:    kind = 3'd4;  // bishop
            3:       kind = 3'd5;  // queen
            default: kind = 3'd6;  // king
        endcase
        if (rank == 0)      return {1'b0, kind};
        else if (rank == 1) return 4'd1;
        else if (rank == 6) return 4'd9;
        else if (rank == 7) return {1'b1, kind};
        else                return 4'd0;
    endfunction

    state_t     state_q, state_d;
    logic [5:0] from_q, from_d;
    logic [5:0] to_q, to_d;
    logic       player_q, player_d;
    logic [5:0] scan_ptr_q, scan_ptr_d;
    logic [1:0] gap_cnt_q, gap_cnt_d;
    logic       move_done_q, move_done_d;
    logic       move_error_q, move_error_d;
    logic [3:0] captured_q, captured_d;
    logic       scan_valid_q, scan_valid_d;
    logic [5:0] scan_index_q, scan_index_d;
    logic [3:0] scan_piece_q, scan_piece_d;
    logic       scan_last_q, scan_last_d;

    logic [3:0] board [0:63];
    logic [3:0] src_code;
    logic [3:0] dst_code;
    logic [3:0] wr_code;
    logic       move_illegal;
    logic       wr_en;

    assign src_code = board[from_q];
    assign dst_code = board[to_q];

    // Basic legality: source must be ours, destination empty or theirs.
    always_comb begin
        move_illegal = 1'b0;
        if (src_code == 4'd0)                                move_illegal = 1'b1;
        if (src_code[3] != player_q)                         move_illegal = 1'b1;
        if ((dst_code != 4'd0) && (dst_code[3] == player_q)) move_illegal = 1'b1;
        if (from_q == to_q)                                  move_illegal = 1'b1;
    end

    assign wr_en = (state_q == APPLY) && !move_illegal;

`ifdef BOARD_PROMOTION_EN
    // A pawn arriving on the far rank becomes a queen of its own colour.
    always_comb begin
        wr_code = src_code;
        if ((src_code == 4'd1) && (to_q[5:3] == 3'd7)) wr_code = 4'd5;
        if ((src_code == 4'd9) && (to_q[5:3] == 3'd0)) wr_code = 4'd13;
    end
`else
    assign wr_code = src_code;
`endif

    // One register per square; each square only watches for its own index.
    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_sq
            localparam logic [3:0] START_CODE = start_code(gi);
            localparam logic [5:0] SQ         = 6'(gi);
            logic [3:0] sq_q, sq_d;

            // Next square contents: reload, destination write, or source clear.
            always_comb begin
                sq_d = sq_q;
                if (new_game)                  sq_d = START_CODE;
                else if (wr_en && to_q == SQ)   sq_d = wr_code;
                else if (wr_en && from_q == SQ) sq_d = 4'd0;
            end

            // Square register, loaded with the start position on reset.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) sq_q <= START_CODE;
                else       sq_q <= sq_d;
            end

            assign board[gi] = sq_q;
        end
    endgenerate

    // Next-state and registered-output logic for the move/scan controller.
    always_comb begin
        state_d      = state_q;
        from_d       = from_q;
        to_d         = to_q;
        player_d     = player_q;
        scan_ptr_d   = scan_ptr_q;
        gap_cnt_d    = gap_cnt_q;
        captured_d   = captured_q;
        scan_index_d = scan_index_q;
        scan_piece_d = scan_piece_q;
        move_done_d  = 1'b0;
        move_error_d = 1'b0;
        scan_valid_d = 1'b0;
        scan_last_d  = 1'b0;

        if (new_game) begin
            // Same effect as reset; any in-flight move or scan is dropped.
            state_d      = IDLE;
            from_d       = 6'd0;
            to_d         = 6'd0;
            player_d     = START_PLAYER;
            scan_ptr_d   = 6'd0;
            gap_cnt_d    = 2'd0;
            captured_d   = 4'd0;
            scan_index_d = 6'd0;
            scan_piece_d = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (move_valid) begin
                        from_d  = move_from;
                        to_d    = move_to;
                        state_d = APPLY;
                    end else if (scan_start) begin
                        scan_ptr_d = 6'd0;
                        state_d    = SCAN;
                    end
                end
                APPLY: begin
                    move_done_d  = 1'b1;
                    move_error_d = move_illegal;
                    if (!move_illegal) begin
                        captured_d = dst_code;
                        player_d   = ~player_q;
                    end
                    state_d = IDLE;
                end
                SCAN: begin
                    scan_valid_d = 1'b1;
                    scan_index_d = scan_ptr_q;
                    scan_piece_d = board[scan_ptr_q];
                    if (scan_ptr_q == 6'd63) begin
                        scan_last_d = 1'b1;
                        state_d     = IDLE;
                    end else if (SCAN_GAP == 0) begin
                        scan_ptr_d = scan_ptr_q + 6'd1;
                    end else begin
                        gap_cnt_d = GAP_LOAD;
                        state_d   = SCAN_WAIT;
                    end
                end
                SCAN_WAIT: begin
                    if (gap_cnt_q == 2'd0) begin
                        scan_ptr_d = scan_ptr_q + 6'd1;
                        state_d    = SCAN;
                    end else begin
                        gap_cnt_d = gap_cnt_q - 2'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Controller registers with asynchronous reset to the idle start state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            from_q       <= 6'd0;
            to_q         <= 6'd0;
            player_q     <= START_PLAYER;
            scan_ptr_q   <= 6'd0;
            gap_cnt_q    <= 2'd0;
            move_done_q  <= 1'b0;
            move_error_q <= 1'b0;
            captured_q   <= 4'd0;
            scan_valid_q <= 1'b0;
            scan_index_q <= 6'd0;
            scan_piece_q <= 4'd0;
            scan_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            from_q       <= from_d;
            to_q         <= to_d;
            player_q     <= player_d;
            scan_ptr_q   <= scan_ptr_d;
            gap_cnt_q    <= gap_cnt_d;
            move_done_q  <= move_done_d;
            move_error_q <= move_error_d;
            captured_q   <= captured_d;
            scan_valid_q <= scan_valid_d;
            scan_index_q <= scan_index_d;
            scan_piece_q <= scan_piece_d;
            scan_last_q  <= scan_last_d;
        end
    end

    assign move_ready = (state_q == IDLE) && !new_game;
    assign busy       = (state_q != IDLE);
    assign move_done  = move_done_q;
    assign move_error = move_error_q;
    assign captured   = captured_q;
    assign player     = player_q;
    assign scan_valid = scan_valid_q;
    assign scan_index = scan_index_q;
    assign scan_piece = scan_piece_q;
    assign scan_last  = scan_last_q;

endmodule

// File: tb/tb_board_state_manager.sv
// Testbench for board_state_manager: directed scenarios plus randomized
// moves checked against a square-array reference model of the game rules.
module tb_board_state_manager;

    localparam logic START = 1'b0;
    localparam int   GAP   = 0;
`ifdef BOARD_PROMOTION_EN
    localparam int PROMO_EXPECT = 5;
`else
    localparam int PROMO_EXPECT = 1;
`endif

    logic       clock;
    logic       reset;
    logic       new_game;
    logic       move_valid;
    logic       move_ready;
    logic [5:0] move_from;
    logic [5:0] move_to;
    logic       move_done;
    logic       move_error;
    logic [3:0] captured;
    logic       player;
    logic       scan_start;
    logic       scan_valid;
    logic [5:0] scan_index;
    logic [3:0] scan_piece;
    logic       scan_last;
    logic       busy;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: plain array of codes, side to move, last capture.
    int mb [64];
    int mp;
    int mcap;

    board_state_manager #(.START_PLAYER(START), .SCAN_GAP(GAP)) dut (
        .clock      (clock),
        .reset      (reset),
        .new_game   (new_game),
        .move_valid (move_valid),
        .move_ready (move_ready),
        .move_from  (move_from),
        .move_to    (move_to),
        .move_done  (move_done),
        .move_error (move_error),
        .captured   (captured),
        .player     (player),
        .scan_start (scan_start),
        .scan_valid (scan_valid),
        .scan_index (scan_index),
        .scan_piece (scan_piece),
        .scan_last  (scan_last),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        int back [8];
        back = '{2, 3, 4, 5, 6, 4, 3, 2};
        for (int i = 0; i < 64; i++) begin
            if (i / 8 == 0)      mb[i] = back[i % 8];
            else if (i / 8 == 1) mb[i] = 1;
            else if (i / 8 == 6) mb[i] = 9;
            else if (i / 8 == 7) mb[i] = back[i % 8] + 8;
            else                 mb[i] = 0;
        end
        mp   = int'(START);
        mcap = 0;
    endtask

    task automatic model_move(input int f, input int t, output bit err, output int cap);
        int src;
        int dst;
        int w;
        src = mb[f];
        dst = mb[t];
        err = (src == 0) || (((src / 8) % 2) != mp) ||
              (dst != 0 && ((dst / 8) % 2) == mp) || (f == t);
        if (!err) begin
            w = src;
`ifdef BOARD_PROMOTION_EN
            if (src == 1 && t / 8 == 7) w = 5;
            if (src == 9 && t / 8 == 0) w = 13;
`endif
            mb[t] = w;
            mb[f] = 0;
            mcap  = dst;
            mp    = 1 - mp;
        end
        cap = mcap;
    endtask

    // Present one move; lat = edges from acceptance (counted as 1) to move_done.
    task automatic drive_move(input int f, input int t, output int lat,
                              output logic err, output logic [3:0] cap);
        int guard;
        guard = 0;
        lat   = -1;
        err   = 1'bx;
        cap   = 4'bx;
        while (!move_ready && guard < 100) begin
            @(posedge clock); #1;
            guard++;
        end
        move_from  = 6'(f);
        move_to    = 6'(t);
        move_valid = 1'b1;
        @(posedge clock); #1;
        move_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (move_done) begin
                lat = i + 1;
                err = move_error;
                cap = captured;
                break;
            end
            @(posedge clock); #1;
        end
        $display("[TB] move %0d->%0d lat=%0d err=%0b cap=%0d player=%0b", f, t, lat, err, cap, player);
    endtask

    // Move with checks of latency, error, capture and side to move.
    task automatic checked_move(input string tag, input int f, input int t);
        int         lat;
        logic       err;
        logic [3:0] cap;
        bit         exp_err;
        int         exp_cap;
        model_move(f, t, exp_err, exp_cap);
        drive_move(f, t, lat, err, cap);
        tests_run++;
        if (lat != 2 || err !== exp_err || cap !== 4'(exp_cap) || player !== mp[0]) begin
            tests_failed++;
            $display("FAIL %s: lat=%0d err=%0b cap=%0d player=%0b, required lat=2 err=%0b cap=%0d player=%0d",
                     tag, lat, err, cap, player, exp_err, exp_cap, mp);
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (busy && guard < 300) begin
            @(posedge clock); #1;
            guard++;
        end
    endtask

    // Full stream: every beat checked for index, piece, timing and last flag.
    task automatic test_full_scan(input string tag);
        int beats;
        bit done;
        wait_idle();
        scan_start = 1'b1;
        @(posedge clock); #1;
        scan_start = 1'b0;
        beats = 0;
        done  = 0;
        for (int cyc = 0; cyc < 64 * (GAP + 1) + 8 && !done; cyc++) begin
            @(posedge clock); #1;
            if (scan_valid) begin
                tests_run++;
                if (beats > 63) begin
                    tests_failed++;
                    $display("FAIL %s beat overflow: got beat %0d, required at most 64 beats", tag, beats);
                    done = 1;
                end else if (scan_index !== 6'(beats) || scan_piece !== 4'(mb[beats]) ||
                             cyc != beats * (GAP + 1) || scan_last !== (beats == 63)) begin
                    tests_failed++;
                    $display("FAIL %s beat %0d: idx=%0d piece=%0d last=%0b cyc=%0d, required idx=%0d piece=%0d last=%0b cyc=%0d",
                             tag, beats, scan_index, scan_piece, scan_last, cyc, beats, mb[beats],
                             beats == 63, beats * (GAP + 1));
                end
                if (scan_last) done = 1;
                beats++;
            end
        end
        tests_run++;
        if (beats != 64) begin
            tests_failed++;
            $display("FAIL %s beat count: got %0d, required 64", tag, beats);
        end
        $display("[TB] scan %s: %0d beats", tag, beats);
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        new_game   = 1'b0;
        move_valid = 1'b0;
        move_from  = 6'd0;
        move_to    = 6'd0;
        scan_start = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if (move_done !== 1'b0 || move_error !== 1'b0 || captured !== 4'd0 || scan_valid !== 1'b0 ||
            scan_index !== 6'd0 || scan_piece !== 4'd0 || scan_last !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset outputs: done=%0b err=%0b cap=%0d sv=%0b si=%0d sp=%0d sl=%0b, required all 0",
                     move_done, move_error, captured, scan_valid, scan_index, scan_piece, scan_last);
        end
        tests_run++;
        if (player !== START || busy !== 1'b0 || move_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset state: player=%0b busy=%0b ready=%0b, required player=%0b busy=0 ready=1",
                     player, busy, move_ready, START);
        end
        $display("[TB] reset released");
    endtask

    task automatic test_rejected();
        checked_move("reject empty src", 20, 28);
        checked_move("reject black src", 52, 44);
        checked_move("reject own dst", 0, 1);
        checked_move("reject same sq", 12, 12);
        test_full_scan("after rejects");
    endtask

    task automatic test_legal_move();
        checked_move("e2e4", 12, 28);
        checked_move("d7d5", 51, 35);
        test_full_scan("after e2e4");
    endtask

    task automatic test_capture();
        checked_move("e4xd5", 28, 35);
        tests_run++;
        if (captured !== 4'd9) begin
            tests_failed++;
            $display("FAIL capture code: got %0d, required 9", captured);
        end
        checked_move("reject white src for black", 0, 1);
    endtask

    task automatic test_async_reset();
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (player !== START || captured !== 4'd0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL async reset: player=%0b cap=%0d busy=%0b, required player=%0b cap=0 busy=0",
                     player, captured, busy, START);
        end
        #1;
        reset = 1'b0;
        model_reset();
        $display("[TB] async reset applied mid-cycle");
        test_full_scan("after async reset");
    endtask

    task automatic test_new_game_abort();
        bit found;
        checked_move("e2e4 again", 12, 28);
        wait_idle();
        scan_start = 1'b1;
        @(posedge clock); #1;
        scan_start = 1'b0;
        found = 0;
        for (int cyc = 0; cyc < 200 && !found; cyc++) begin
            @(posedge clock); #1;
            tests_run++;
            if (scan_valid && scan_index < 6'd30 && move_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL ready during scan: got %0b, required 0", move_ready);
            end
            if (scan_valid && scan_index == 6'd30) found = 1;
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL beat 30 wait: not seen, required within 200 cycles");
        end
        new_game = 1'b1;
        #1;
        tests_run++;
        if (move_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL ready with new_game: got %0b, required 0", move_ready);
        end
        @(posedge clock); #1;
        new_game = 1'b0;
        model_reset();
        tests_run++;
        if (scan_valid !== 1'b0 || scan_last !== 1'b0 || player !== START || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL new_game abort: sv=%0b sl=%0b player=%0b busy=%0b, required sv=0 sl=0 player=%0b busy=0",
                     scan_valid, scan_last, player, busy, START);
        end
        $display("[TB] new_game during beat 30");
        test_full_scan("after new_game");
    endtask

    task automatic test_promotion();
        checked_move("e2xe7", 12, 52);
        checked_move("ke8-e6", 60, 44);
        checked_move("e7-e8", 52, 60);
        tests_run++;
        if (mb[60] != PROMO_EXPECT) begin
            tests_failed++;
            $display("FAIL promotion model: got %0d, required %0d", mb[60], PROMO_EXPECT);
        end
        test_full_scan("after promotion");
    endtask

    task automatic test_random_moves();
        int own [$];
        int f;
        int t;
        for (int n = 0; n < 150; n++) begin
            own.delete();
            for (int i = 0; i < 64; i++)
                if (mb[i] != 0 && ((mb[i] / 8) % 2) == mp) own.push_back(i);
            if (own.size() > 0 && $urandom_range(3) != 0)
                f = own[$urandom_range(own.size() - 1)];
            else
                f = int'($urandom_range(63));
            if (own.size() > 0 && $urandom_range(4) == 0)
                t = own[$urandom_range(own.size() - 1)];
            else
                t = int'($urandom_range(63));
            checked_move("random move", f, t);
            if (n % 50 == 49) test_full_scan("random");
        end
    endtask

    initial begin
        test_reset();
        test_rejected();
        test_legal_move();
        test_capture();
        test_async_reset();
        test_new_game_abort();
        test_promotion();
        test_random_moves();
        test_full_scan("final");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
